// File: rtl/hazard_ctrl_if.sv
// hazard_ctrl_if: OF/EX/WB-side signals of the pipeline interlock controller.
// master = pipeline (drives instruction/WB info), slave = hazard_ctrl.
interface hazard_ctrl_if #(
    parameter int unsigned CNT_W = 16
);
    logic             of_valid;
    logic [3:0]       of_rs1;
    logic [3:0]       of_rs2;
    logic [3:0]       of_rd;
    logic             of_use_rs1;
    logic             of_use_rs2;
    logic             of_wr_rd;
    logic             of_mc;
    logic             ex_branch_taken;
    logic             wb_valid;
    logic [3:0]       wb_adr;
    logic             stall;
    logic             bubble;
    logic             flush;
    logic             ex_hold;
    logic [15:0]      busy_mask;
    logic [CNT_W-1:0] stall_cnt;

    modport master (
        output of_valid, of_rs1, of_rs2, of_rd, of_use_rs1, of_use_rs2, of_wr_rd, of_mc,
        output ex_branch_taken, wb_valid, wb_adr,
        input  stall, bubble, flush, ex_hold, busy_mask, stall_cnt
    );

    modport slave (
        input  of_valid, of_rs1, of_rs2, of_rd, of_use_rs1, of_use_rs2, of_wr_rd, of_mc,
        input  ex_branch_taken, wb_valid, wb_adr,
        output stall, bubble, flush, ex_hold, busy_mask, stall_cnt
    );
endinterface

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: operand-fetch interlock for the 5-stage pipeline. Tracks pending register
// writes in a scoreboard and freezes the front end while a multi-cycle EX op runs.
module hazard_ctrl #(
    parameter int unsigned MC_LAT = 4,
    parameter int unsigned CNT_W  = 16
) (
    input logic          clk,
    input logic          reset,
    hazard_ctrl_if.slave bus
);
    typedef enum logic [0:0] {StRun, StMcWait} state_e;

    state_e           state_q, state_d;
    logic [15:0]      pending_q, pending_d;
    logic [3:0]       cnt_q, cnt_d;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic             hazard;
    logic             issue;
    logic             stall;
    logic             bubble;
    logic             flush;

    // The WAW term keeps an older pending write from landing after a newer one.
    assign hazard = bus.of_valid & ((bus.of_use_rs1 & pending_q[bus.of_rs1]) |
                                    (bus.of_use_rs2 & pending_q[bus.of_rs2]) |
                                    (bus.of_wr_rd   & pending_q[bus.of_rd]));

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        stall   = 1'b0;
        bubble  = 1'b0;
        flush   = 1'b0;
        issue   = 1'b0;
        unique case (state_q)
            StRun: begin
                if (bus.ex_branch_taken) begin
                    flush = 1'b1;
                end else if (hazard) begin
                    stall  = 1'b1;
                    bubble = 1'b1;
                end else if (bus.of_valid) begin
                    issue = 1'b1;
                    if (bus.of_mc) begin
                        cnt_d   = 4'(MC_LAT - 1);
                        state_d = StMcWait;
                    end
                end
            end
            StMcWait: begin
                // A taken branch here is illegal and deliberately ignored.
                stall = 1'b1;
                cnt_d = cnt_q - 4'd1;
                if (cnt_q == 4'd1) begin
                    state_d = StRun;
                end
            end
            default: ;
        endcase
    end

    always_comb begin
        pending_d = pending_q;
        if (bus.wb_valid) begin
            pending_d[bus.wb_adr] = 1'b0;
        end
        // Set after clear so a same-cycle issue to the written register wins.
        if (issue && bus.of_wr_rd) begin
            pending_d[bus.of_rd] = 1'b1;
        end
        stall_cnt_d = stall_cnt_q;
        if (stall && (stall_cnt_q != {CNT_W{1'b1}})) begin
            stall_cnt_d = stall_cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= StRun;
            pending_q   <= '0;
            cnt_q       <= '0;
            stall_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            pending_q   <= pending_d;
            cnt_q       <= cnt_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    // Combinational controls are forced low while reset is held.
    assign bus.stall     = stall & reset;
    assign bus.bubble    = bubble & reset;
    assign bus.flush     = flush & reset;
    assign bus.ex_hold   = (state_q == StMcWait);
    assign bus.busy_mask = pending_q;
    assign bus.stall_cnt = stall_cnt_q;
endmodule

// File: tb/tb_hazard_ctrl.sv
// tb_hazard_ctrl: directed scenarios plus randomized traffic checked against a
// behavioural model of the interlock rules (scoreboard bits, remaining hold cycles).
module tb_hazard_ctrl;
    localparam int unsigned MC_LAT = 4;
    localparam int unsigned CNT_W  = 16;
    localparam int unsigned CntMax = (32'd1 << CNT_W) - 32'd1;

    logic clk = 1'b0;
    logic reset = 1'b0;
    int   checks = 0;
    int   errors = 0;

    hazard_ctrl_if #(.CNT_W(CNT_W)) bus ();

    hazard_ctrl #(.MC_LAT(MC_LAT), .CNT_W(CNT_W)) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not finish, got timeout required finish");
        $fatal(1, "watchdog expired");
    end

    assert property (@(posedge clk) disable iff (!reset) !(bus.ex_hold && bus.ex_branch_taken))
        else $error("protocol violation: branch taken during multi-cycle hold");

    // Model state: pending writes, cycles of hold remaining, stall count.
    bit [15:0]   m_pend;
    int          m_left;
    int unsigned m_scnt;
    logic        e_stall, e_bubble, e_flush, e_hold, e_issue;

    task automatic model_comb();
        bit haz;
        e_stall = 0; e_bubble = 0; e_flush = 0; e_hold = 0; e_issue = 0;
        if (reset) begin
            haz = bus.of_valid && ((bus.of_use_rs1 && m_pend[bus.of_rs1]) ||
                                   (bus.of_use_rs2 && m_pend[bus.of_rs2]) ||
                                   (bus.of_wr_rd && m_pend[bus.of_rd]));
            if (m_left > 0) begin
                e_stall = 1; e_hold = 1;
            end else if (bus.ex_branch_taken) begin
                e_flush = 1;
            end else if (haz) begin
                e_stall = 1; e_bubble = 1;
            end else if (bus.of_valid) begin
                e_issue = 1;
            end
        end
    endtask

    task automatic model_reset();
        reset  = 1'b0;
        m_pend = '0;
        m_left = 0;
        m_scnt = 0;
    endtask

    // Advance one clock edge, applying the rules to the model; returns 1ns after the edge.
    task automatic tick();
        model_comb();
        @(posedge clk);
        if (reset) begin
            if (m_left > 0) m_left--;
            else if (e_issue && bus.of_mc) m_left = MC_LAT - 1;
            if (bus.wb_valid) m_pend[bus.wb_adr] = 1'b0;
            if (e_issue && bus.of_wr_rd) m_pend[bus.of_rd] = 1'b1;
            if (e_stall && m_scnt < CntMax) m_scnt++;
        end
        #1;
    endtask

    task automatic drive(input logic v, input logic [3:0] rs1, input logic [3:0] rs2,
                         input logic [3:0] rd, input logic u1, input logic u2, input logic wr,
                         input logic mc, input logic br, input logic wbv,
                         input logic [3:0] wba);
        bus.of_valid = v; bus.of_rs1 = rs1; bus.of_rs2 = rs2; bus.of_rd = rd;
        bus.of_use_rs1 = u1; bus.of_use_rs2 = u2; bus.of_wr_rd = wr; bus.of_mc = mc;
        bus.ex_branch_taken = br; bus.wb_valid = wbv; bus.wb_adr = wba;
        #1;
    endtask

    task automatic idle();
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic test_reset();
        model_reset();
        drive(1, 1, 2, 3, 1, 1, 1, 1, 1, 1, 4);
        for (int i = 0; i < 2; i++) begin
            checks++;
            if ({bus.stall, bus.bubble, bus.flush, bus.ex_hold} !== 4'b0000) begin
                errors++;
                $display("FAIL reset_ctl: got %b required 0000",
                         {bus.stall, bus.bubble, bus.flush, bus.ex_hold});
            end
            checks++;
            if (bus.busy_mask !== 16'h0 || bus.stall_cnt !== '0) begin
                errors++;
                $display("FAIL reset_state: busy %h cnt %h required 0 0",
                         bus.busy_mask, bus.stall_cnt);
            end
            tick();
        end
        idle();
        reset = 1'b1;
        for (int r = 1; r <= 3; r++) begin
            if (r < 3) drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 4'(r));
            else idle();
            model_comb();
            checks++;
            if ({bus.stall, bus.bubble, bus.flush, bus.ex_hold, bus.busy_mask, bus.stall_cnt}
                !== {4'b0000, 16'h0, {CNT_W{1'b0}}}) begin
                errors++;
                $display("FAIL reset_wb: ctl %b busy %h cnt %h required all 0",
                         {bus.stall, bus.bubble, bus.flush, bus.ex_hold},
                         bus.busy_mask, bus.stall_cnt);
            end
            tick();
        end
    endtask

    task automatic test_raw_stall();
        drive(1, 0, 0, 3, 0, 0, 1, 0, 0, 0, 0);
        tick();
        // Consumer reads r3 and also rewrites r3.
        for (int i = 0; i < 6; i++) begin
            case (i)
                3: drive(1, 3, 0, 3, 1, 0, 1, 0, 0, 1, 3);
                5: idle();
                default: drive(1, 3, 0, 3, 1, 0, 1, 0, 0, 0, 0);
            endcase
            model_comb();
            checks++;
            if ({bus.stall, bus.bubble, bus.flush, bus.ex_hold} !==
                {e_stall, e_bubble, e_flush, e_hold}) begin
                errors++;
                $display("FAIL raw_ctl[%0d]: got %b required %b", i,
                         {bus.stall, bus.bubble, bus.flush, bus.ex_hold},
                         {e_stall, e_bubble, e_flush, e_hold});
            end
            checks++;
            if (bus.busy_mask !== m_pend) begin
                errors++;
                $display("FAIL raw_busy[%0d]: got %h required %h", i, bus.busy_mask, m_pend);
            end
            tick();
        end
    endtask

    task automatic test_multicycle();
        int          holds = 0;
        int unsigned scnt0;
        drive(1, 0, 0, 5, 0, 0, 1, 1, 0, 0, 0);
        scnt0 = m_scnt;
        tick();
        for (int i = 0; i < 20; i++) begin
            drive(1, 1, 2, 6, 1, 1, 1, 0, 0, 0, 0);
            model_comb();
            checks++;
            if ({bus.stall, bus.bubble, bus.flush, bus.ex_hold} !==
                {e_stall, e_bubble, e_flush, e_hold}) begin
                errors++;
                $display("FAIL mc_ctl[%0d]: got %b required %b", i,
                         {bus.stall, bus.bubble, bus.flush, bus.ex_hold},
                         {e_stall, e_bubble, e_flush, e_hold});
            end
            if (!bus.ex_hold) break;
            holds++;
            tick();
        end
        tick();
        idle();
        checks++;
        if (holds != MC_LAT - 1) begin
            errors++;
            $display("FAIL mc_len: got %0d hold cycles required %0d", holds, MC_LAT - 1);
        end
        checks++;
        if (bus.stall_cnt !== CNT_W'(scnt0 + MC_LAT - 1) || bus.busy_mask !== m_pend) begin
            errors++;
            $display("FAIL mc_cnt: cnt %0d busy %h required %0d %h", bus.stall_cnt,
                     bus.busy_mask, scnt0 + MC_LAT - 1, m_pend);
        end
    endtask

    task automatic test_branch_flush();
        drive(1, 0, 0, 4, 0, 0, 1, 0, 0, 0, 0);
        tick();
        drive(1, 4, 0, 8, 1, 0, 1, 0, 1, 0, 0);
        model_comb();
        checks++;
        if ({bus.stall, bus.bubble, bus.flush, bus.ex_hold} !== 4'b0010 || !e_flush) begin
            errors++;
            $display("FAIL br_ctl: got %b required 0010",
                     {bus.stall, bus.bubble, bus.flush, bus.ex_hold});
        end
        tick();
        idle();
        checks++;
        if (bus.busy_mask !== m_pend || bus.busy_mask[8] !== 1'b0) begin
            errors++;
            $display("FAIL br_busy: got %h required %h", bus.busy_mask, m_pend);
        end
    endtask

    task automatic test_back_to_back();
        model_reset();
        idle();
        tick();
        reset = 1'b1;
        for (int i = 0; i < 6; i++) begin
            drive(1, 4'(i + 8), 4'(i + 9), 4'(i + 1), 1, 1, 1, 0, 0, 0, 0);
            model_comb();
            checks++;
            if (bus.stall !== 1'b0 || bus.bubble !== 1'b0 || !e_issue) begin
                errors++;
                $display("FAIL b2b_stall[%0d]: stall %b bubble %b required 0 0", i,
                         bus.stall, bus.bubble);
            end
            tick();
        end
        idle();
        checks++;
        if (bus.busy_mask !== 16'h007E || bus.busy_mask !== m_pend) begin
            errors++;
            $display("FAIL b2b_busy: got %h required 007e", bus.busy_mask);
        end
    endtask

    task automatic test_collision_saturate();
        model_reset();
        idle();
        tick();
        reset = 1'b1;
        drive(1, 0, 0, 7, 0, 0, 1, 0, 0, 1, 7);
        tick();
        idle();
        checks++;
        if (bus.busy_mask !== 16'h0080 || m_pend !== 16'h0080) begin
            errors++;
            $display("FAIL collide_busy: got %h required 0080", bus.busy_mask);
        end
        drive(1, 7, 0, 9, 1, 0, 1, 0, 0, 0, 0);
        for (int i = 0; i < 70000 && m_scnt < CntMax; i++) tick();
        checks++;
        if (bus.stall_cnt !== {CNT_W{1'b1}} || m_scnt != CntMax) begin
            errors++;
            $display("FAIL sat_reach: got %h required all-ones", bus.stall_cnt);
        end
        tick();
        checks++;
        if (bus.stall !== 1'b1 || bus.stall_cnt !== {CNT_W{1'b1}}) begin
            errors++;
            $display("FAIL sat_hold: stall %b cnt %h required 1 all-ones",
                     bus.stall, bus.stall_cnt);
        end
        idle();
    endtask

    task automatic test_reset_mcwait();
        drive(1, 0, 0, 9, 0, 0, 1, 1, 0, 0, 0);
        tick();
        idle();
        tick();
        checks++;
        if (bus.ex_hold !== 1'b1) begin
            errors++;
            $display("FAIL rmc_pre: ex_hold %b required 1", bus.ex_hold);
        end
        model_reset();
        #1;
        checks++;
        if (bus.ex_hold !== 1'b0 || bus.busy_mask !== 16'h0 || bus.stall !== 1'b0) begin
            errors++;
            $display("FAIL rmc_abort: hold %b busy %h stall %b required 0 0 0",
                     bus.ex_hold, bus.busy_mask, bus.stall);
        end
        tick();
        reset = 1'b1;
        drive(1, 9, 5, 9, 1, 1, 1, 0, 0, 0, 0);
        model_comb();
        checks++;
        if (bus.stall !== 1'b0 || bus.ex_hold !== 1'b0 || !e_issue) begin
            errors++;
            $display("FAIL rmc_issue: stall %b hold %b required 0 0", bus.stall, bus.ex_hold);
        end
        tick();
        idle();
        checks++;
        if (bus.busy_mask !== 16'h0200) begin
            errors++;
            $display("FAIL rmc_busy: got %h required 0200", bus.busy_mask);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 3000; i++) begin
            drive($urandom_range(0, 9) < 8, 4'($urandom_range(0, 7)), 4'($urandom_range(0, 7)),
                  4'($urandom_range(0, 7)), 1'($urandom), 1'($urandom),
                  $urandom_range(0, 3) != 0, $urandom_range(0, 19) == 0,
                  (m_left == 0) && ($urandom_range(0, 9) == 0),
                  $urandom_range(0, 9) < 4, 4'($urandom_range(0, 7)));
            model_comb();
            checks++;
            if ({bus.stall, bus.bubble, bus.flush, bus.ex_hold, bus.busy_mask, bus.stall_cnt} !==
                {e_stall, e_bubble, e_flush, e_hold, m_pend, CNT_W'(m_scnt)}) begin
                errors++;
                $display("FAIL rand[%0d]: ctl %b busy %h cnt %0d required %b %h %0d", i,
                         {bus.stall, bus.bubble, bus.flush, bus.ex_hold}, bus.busy_mask,
                         bus.stall_cnt, {e_stall, e_bubble, e_flush, e_hold}, m_pend, m_scnt);
            end
            tick();
        end
        idle();
    endtask

    initial begin
        test_reset();
        test_raw_stall();
        test_multicycle();
        test_branch_flush();
        test_back_to_back();
        test_random();
        test_collision_saturate();
        test_reset_mcwait();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
